// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and memory-freeze control with saturating perf counters
module pipeline_hazard_ctrl #(
  parameter int ASIZE = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [ASIZE-1:0] id_raddr1,
  input  logic [ASIZE-1:0] id_raddr2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_memRead,
  input  logic             ex_wen,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             pc_sel_branch,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, FREEZE = 2'd1, RESUME = 2'd2} state_t;
  state_t state, state_nxt;
  logic load_use, frozen, branch, stall;
  always_ff @(posedge clk) state <= state_nxt;
  always_comb begin
    load_use = id_valid & ex_memRead & ex_wen & (ex_waddr != '0) &
               ((id_rs1_used & (id_raddr1 == ex_waddr)) | (id_rs2_used & (id_raddr2 == ex_waddr)));
    frozen = ~rst & ((state == FREEZE) | mem_busy);
    branch = ~rst & ~frozen & ex_branch_taken;
    stall = ~rst & ~frozen & ~ex_branch_taken & load_use;
    state_nxt = rst ? RUN : mem_busy ? FREEZE : (state == FREEZE) ? RESUME : RUN;
    pc_en = ~frozen & ~stall;
    ifid_en = ~frozen & ~stall;
    idex_en = ~frozen;
    exmem_en = ~frozen;
    pc_sel_branch = branch;
    ifid_flush = branch;
    idex_bubble = branch | stall;
  end
  assign state_o = state;
  // counters hold at all-ones instead of wrapping; clear beats increment
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (branch && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      if (frozen && freeze_cnt != '1) freeze_cnt <= freeze_cnt + 1'b1;
    end
  end
endmodule
